// File: rtl/ram_design.sv
// ram_design
// Single-port synchronous scratch RAM, DEPTH words of DATA_W bits, with
// separate write/read strobes and a registered read port. Every word and the
// output register are held in resettable flops.
//
// Ports:
//   clk      - system clock, rising-edge active
//   rst_n    - asynchronous active-low reset; clears memory and outputs
//   address  - word address shared by read and write
//   data_in  - write data
//   wr       - write strobe (takes priority over rd)
//   rd       - read strobe
//   data_out - registered read data; changes only on a read or reset
//   rd_valid - one-cycle pulse when data_out was just loaded by a read
module ram_design #(
   parameter int unsigned ADDR_W = 4,
   parameter int unsigned DATA_W = 4,
   parameter int unsigned DEPTH  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] address,
   input  logic [DATA_W-1:0] data_in,
   input  logic              wr,
   input  logic              rd,
   output logic [DATA_W-1:0] data_out,
   output logic              rd_valid
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];
   logic [DATA_W-1:0] data_out_q, data_out_d;
   logic              rd_valid_q, rd_valid_d;

   always_comb begin
      mem_d      = mem_q;
      data_out_d = data_out_q;
      rd_valid_d = 1'b0;
      // Write wins when both strobes are high; the read is dropped entirely.
      if (wr) begin
         mem_d[address] = data_in;
      end else if (rd) begin
         data_out_d = mem_q[address];
         rd_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         data_out_q <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         mem_q      <= mem_d;
         data_out_q <= data_out_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   assign data_out = data_out_q;
   assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_ram_design.sv
// tb_ram_design
// Directed self-checking bench for ram_design: fill/readback with wrap,
// asynchronous reset clearing, write priority, hold, back-to-back RAW,
// overwrite and a write aborted by reset.
module tb_ram_design;

   logic       clk;
   logic       rst_n;
   logic [3:0] address;
   logic [3:0] data_in;
   logic       wr;
   logic       rd;
   logic [3:0] data_out;
   logic       rd_valid;

   int unsigned errors = 0;
   int unsigned checks = 0;

   ram_design #(.ADDR_W(4), .DATA_W(4), .DEPTH(16)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .address  (address),
      .data_in  (data_in),
      .wr       (wr),
      .rd       (rd),
      .data_out (data_out),
      .rd_valid (rd_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge and settle just after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_write(input logic [3:0] a, input logic [3:0] d);
      wr = 1'b1; rd = 1'b0; address = a; data_in = d;
      tick();
      wr = 1'b0;
   endtask

   task automatic do_read(input logic [3:0] a);
      wr = 1'b0; rd = 1'b1; address = a;
      tick();
      rd = 1'b0;
   endtask

   initial begin
      logic [3:0] exp_d;
      rst_n = 1'b0; address = '0; data_in = '0; wr = 1'b0; rd = 1'b0;
      #1;
      chk("reset_data_out", {4'h0, data_out}, 8'h00);
      chk("reset_rd_valid", {7'h0, rd_valid}, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;

      // Fill and read back; 15+1 wraps to 0 in four bits.
      for (int a = 0; a < 16; a++) begin
         exp_d = (a == 15) ? 4'h0 : 4'(a + 1);
         do_write(4'(a), 4'(a + 1));
         chk("fill_wr_no_valid", {7'h0, rd_valid}, 8'h00);
         do_read(4'(a));
         chk("fill_data", {4'h0, data_out}, {4'h0, exp_d});
         chk("fill_valid", {7'h0, rd_valid}, 8'h01);
      end
      tick();
      chk("fill_valid_drop", {7'h0, rd_valid}, 8'h00);

      // Reset clears, asserted between edges.
      do_write(4'h3, 4'hA);
      do_read(4'h3);
      chk("pre_reset_data", {4'h0, data_out}, 8'h0A);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_data", {4'h0, data_out}, 8'h00);
      chk("async_rst_valid", {7'h0, rd_valid}, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;
      do_read(4'h3);
      chk("post_rst_read", {4'h0, data_out}, 8'h00);
      chk("post_rst_valid", {7'h0, rd_valid}, 8'h01);

      // Write priority over simultaneous read.
      do_write(4'h5, 4'h2);
      do_write(4'h6, 4'h7);
      do_read(4'h6);
      chk("prio_setup", {4'h0, data_out}, 8'h07);
      wr = 1'b1; rd = 1'b1; address = 4'h5; data_in = 4'h9;
      tick();
      wr = 1'b0; rd = 1'b0;
      chk("prio_hold_data", {4'h0, data_out}, 8'h07);
      chk("prio_no_valid", {7'h0, rd_valid}, 8'h00);
      do_read(4'h5);
      chk("prio_readback", {4'h0, data_out}, 8'h09);

      // Hold across idle cycles with a moving address.
      do_write(4'h1, 4'h2);
      do_read(4'h1);
      chk("hold_read", {4'h0, data_out}, 8'h02);
      for (int i = 0; i < 5; i++) begin
         address = 4'(i * 3 + 4);
         tick();
         chk("hold_data", {4'h0, data_out}, 8'h02);
         chk("hold_valid", {7'h0, rd_valid}, 8'h00);
      end

      // Back-to-back write then read.
      do_write(4'h8, 4'hF);
      do_read(4'h8);
      chk("b2b_data", {4'h0, data_out}, 8'h0F);

      // Overwrite on consecutive edges.
      do_write(4'h0, 4'h3);
      do_write(4'h0, 4'hC);
      do_read(4'h0);
      chk("overwrite", {4'h0, data_out}, 8'h0C);

      // Write pending when reset hits is lost.
      @(negedge clk);
      wr = 1'b1; address = 4'h4; data_in = 4'h5;
      #2;
      rst_n = 1'b0;
      @(negedge clk);
      wr = 1'b0;
      rst_n = 1'b1;
      do_read(4'h4);
      chk("abort_write", {4'h0, data_out}, 8'h00);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
